// File: rtl/hicore_agu_pkg.sv
// ---------------------------------------------------------------------------
// hicore_agu_pkg
// Shared configuration for the HiCore address generation unit.
//
// The HiCore width macros (address, register and issue-bundle sizes) and the
// misalignment exception bit indices live together at the top of this file
// so that every AGU file sees the same values. The package mirrors them as
// typed localparams and provides the skid-buffer state type and a small
// misalignment helper.
//
// Optional feature macro: HiCore_AGU_MISALIGN_EN (consumed by hicore_agu).
// Info bundle layout, MSB to LSB: {rob_ptr, pc, irq, excp}.
// ---------------------------------------------------------------------------
`ifndef HICORE_CONFIG_DEFINED
`define HICORE_CONFIG_DEFINED
`define HiCore_ADDR_SIZE        32
`define HiCore_REG_SIZE         32
`define HiCore_ROB_PTR_SIZE     4
`define HiCore_EXCP_SIZE        8
`define HiCore_ISSUE2ALU_SIZE   (`HiCore_ROB_PTR_SIZE + `HiCore_ADDR_SIZE + 1 + `HiCore_EXCP_SIZE)
`define HiCore_EXCP_LD_MISALIGN 4
`define HiCore_EXCP_ST_MISALIGN 6
`endif

package hicore_agu_pkg;

  localparam int EXCP_W           = `HiCore_EXCP_SIZE;
  localparam int EXCP_LD_MISALIGN = `HiCore_EXCP_LD_MISALIGN;
  localparam int EXCP_ST_MISALIGN = `HiCore_EXCP_ST_MISALIGN;

  // One-hot exception codes written when an access is misaligned
  localparam logic [EXCP_W-1:0] EXCP_LD_MASK = EXCP_W'(1) << EXCP_LD_MISALIGN;
  localparam logic [EXCP_W-1:0] EXCP_ST_MASK = EXCP_W'(1) << EXCP_ST_MISALIGN;

  // Occupancy of the two-entry in-order buffer between AGU and LSU
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  // Halfwords must sit on even addresses, words on multiples of four;
  // byte accesses are never misaligned.
  function automatic logic agu_is_misaligned(input logic       isShort,
                                             input logic       isWord,
                                             input logic [1:0] offset);
    return (isShort && offset[0]) || (isWord && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/hicore_agu_skid.sv
// ---------------------------------------------------------------------------
// hicore_agu_skid
// Two-entry in-order buffer holding computed AGU requests until the LSU
// accepts them. The head entry is presented combinationally from storage, so
// it stays stable while the consumer stalls.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_flush      drop every entry on the next edge (overrides push/pop)
//   i_push       write i_data as the newest entry (ignored when full)
//   i_data       entry payload, DW bits
//   o_not_full   buffer can take another entry this cycle
//   o_valid      head entry present
//   i_ready      consumer takes the head entry when o_valid is high
//   o_data       head (oldest) entry payload
// ---------------------------------------------------------------------------
module hicore_agu_skid
  import hicore_agu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  output logic          o_not_full,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data
);

  skid_state_e   r_state;
  skid_state_e   w_next_state;
  logic [DW-1:0] r_mem [2];
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic          w_push;
  logic          w_pop;

  assign o_valid    = (r_state != SKID_EMPTY);
  assign o_not_full = (r_state != SKID_TWO);
  assign o_data     = r_mem[r_rd_ptr];

  // A push while full would overwrite the head, so it is masked here as well
  assign w_push = i_push & o_not_full;
  assign w_pop  = o_valid & i_ready;

  // Occupancy register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SKID_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Occupancy transitions; a simultaneous push and pop leaves the count alone
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      SKID_EMPTY: if (w_push) w_next_state = SKID_ONE;
      SKID_ONE: begin
        if (w_push && !w_pop) begin
          w_next_state = SKID_TWO;
        end else if (!w_push && w_pop) begin
          w_next_state = SKID_EMPTY;
        end
      end
      SKID_TWO: if (w_pop) w_next_state = SKID_ONE;
      default: w_next_state = SKID_EMPTY;
    endcase
    if (i_flush) begin
      w_next_state = SKID_EMPTY;
    end
  end

  // Entry storage and ring pointers; a flush rewinds both pointers so the
  // next entry lands in slot 0 again
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

endmodule

// File: rtl/hicore_agu.sv
// ---------------------------------------------------------------------------
// hicore_agu
// Address generation unit: computes the effective address rs1+imm, the byte
// write mask and the lane-replicated store data for each issued memory op,
// optionally flags misaligned accesses in the exception field, and queues the
// result in a two-entry buffer towards the LSU.
//
// Optional feature: define HiCore_AGU_MISALIGN_EN to raise the load/store
// misalignment exception bits. Without it the info bundle passes unchanged
// and the address is forwarded as computed.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   flush                       commit-stage flush, drops all queued ops
//   i_issue2agu_valid/ready     issue handshake (ready is also high on cancel)
//   i_issue2agu_cancel          squashed request: accepted but not queued
//   i_issue2agu_rs1/rs2/imm     base, store data, offset
//   i_issue2agu_read ... _byte_access   op decode
//   i_issue2agu_info            {rob_ptr, pc, irq, excp}
//   o_agu2lsu_valid/ready       LSU handshake
//   o_agu2lsu_cancel            head entry squashed by a flush this cycle
//   o_agu2lsu_*                 decode, addr, wdata, wmask, info of head entry
// ---------------------------------------------------------------------------
module hicore_agu
  import hicore_agu_pkg::*;
#(
  parameter int AW   = `HiCore_ADDR_SIZE,
  parameter int XLEN = `HiCore_REG_SIZE,
  parameter int IW   = `HiCore_ISSUE2ALU_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,

  input  logic              i_issue2agu_valid,
  output logic              i_issue2agu_ready,
  input  logic              i_issue2agu_cancel,
  input  logic [XLEN-1:0]   i_issue2agu_rs1,
  input  logic [XLEN-1:0]   i_issue2agu_rs2,
  input  logic [XLEN-1:0]   i_issue2agu_imm,
  input  logic              i_issue2agu_read,
  input  logic              i_issue2agu_unsigned,
  input  logic              i_issue2agu_word_access,
  input  logic              i_issue2agu_short_access,
  input  logic              i_issue2agu_byte_access,
  input  logic [IW-1:0]     i_issue2agu_info,

  output logic              o_agu2lsu_valid,
  input  logic              o_agu2lsu_ready,
  output logic              o_agu2lsu_cancel,
  output logic              o_agu2lsu_read,
  output logic              o_agu2lsu_unsigned,
  output logic              o_agu2lsu_word_access,
  output logic              o_agu2lsu_short_access,
  output logic              o_agu2lsu_byte_access,
  output logic [AW-1:0]     o_agu2lsu_addr,
  output logic [XLEN-1:0]   o_agu2lsu_wdata,
  output logic [XLEN/8-1:0] o_agu2lsu_wmask,
  output logic [IW-1:0]     o_agu2lsu_info
);

  localparam int MW = XLEN / 8;
  localparam int DW = 5 + AW + XLEN + MW + IW;

  logic [XLEN-1:0] w_sum;
  logic [AW-1:0]   w_addr;
  logic [MW-1:0]   w_wmask;
  logic [XLEN-1:0] w_wdata;
  logic [IW-1:0]   w_info;
  logic            w_push;
  logic            w_skid_not_full;
  logic            w_skid_valid;
  logic [DW-1:0]   w_push_data;
  logic [DW-1:0]   w_pop_data;

  // Effective address wraps modulo 2^AW
  assign w_sum  = i_issue2agu_rs1 + i_issue2agu_imm;
  assign w_addr = w_sum[AW-1:0];

  // Byte-lane write mask; the shifted pattern is truncated to the bus width
  always_comb begin
    w_wmask = '0;
    if (!i_issue2agu_read) begin
      if (i_issue2agu_byte_access) begin
        w_wmask = MW'(1) << w_addr[1:0];
      end else if (i_issue2agu_short_access) begin
        w_wmask = MW'(3) << w_addr[1:0];
      end else if (i_issue2agu_word_access) begin
        w_wmask = '1;
      end
    end
  end

  // Store data replicated across all lanes so the mask alone selects bytes
  always_comb begin
    w_wdata = i_issue2agu_rs2;
    if (i_issue2agu_byte_access) begin
      w_wdata = {(XLEN/8){i_issue2agu_rs2[7:0]}};
    end else if (i_issue2agu_short_access) begin
      w_wdata = {(XLEN/16){i_issue2agu_rs2[15:0]}};
    end
  end

`ifdef HiCore_AGU_MISALIGN_EN
  logic w_misalign;

  assign w_misalign = agu_is_misaligned(i_issue2agu_short_access,
                                        i_issue2agu_word_access,
                                        w_addr[1:0]);

  // An earlier exception already owns the excp field, so misalignment is
  // only reported when the incoming code is clear
  always_comb begin
    w_info = i_issue2agu_info;
    if (w_misalign && (i_issue2agu_info[EXCP_W-1:0] == '0)) begin
      w_info[EXCP_W-1:0] = i_issue2agu_read ? EXCP_LD_MASK : EXCP_ST_MASK;
    end
  end
`else
  assign w_info = i_issue2agu_info;
`endif

  // A cancelled request is consumed immediately so issue never stalls on it
  assign i_issue2agu_ready = i_issue2agu_cancel | w_skid_not_full;
  assign w_push = i_issue2agu_valid & i_issue2agu_ready
                & ~i_issue2agu_cancel & ~flush;

  assign w_push_data = {i_issue2agu_read,
                        i_issue2agu_unsigned,
                        i_issue2agu_word_access,
                        i_issue2agu_short_access,
                        i_issue2agu_byte_access,
                        w_addr,
                        w_wdata,
                        w_wmask,
                        w_info};

  hicore_agu_skid #(
    .DW(DW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (flush),
    .i_push    (w_push),
    .i_data    (w_push_data),
    .o_not_full(w_skid_not_full),
    .o_valid   (w_skid_valid),
    .i_ready   (o_agu2lsu_ready),
    .o_data    (w_pop_data)
  );

  assign {o_agu2lsu_read,
          o_agu2lsu_unsigned,
          o_agu2lsu_word_access,
          o_agu2lsu_short_access,
          o_agu2lsu_byte_access,
          o_agu2lsu_addr,
          o_agu2lsu_wdata,
          o_agu2lsu_wmask,
          o_agu2lsu_info} = w_pop_data;

  assign o_agu2lsu_valid  = w_skid_valid;
  assign o_agu2lsu_cancel = w_skid_valid & flush;

endmodule

// File: tb/tb_hicore_agu.sv
// ---------------------------------------------------------------------------
// tb_hicore_agu
// Directed bench for hicore_agu: address/mask/data generation, misalignment
// reporting, buffer ordering under back-pressure, cancel, flush and reset.
// Inputs change on the falling edge; outputs are read shortly after it.
// ---------------------------------------------------------------------------
module tb_hicore_agu;

  localparam int IW = `HiCore_ISSUE2ALU_SIZE;

`ifdef HiCore_AGU_MISALIGN_EN
  localparam logic [7:0] EXP_LD_MIS = 8'h10;
  localparam logic [7:0] EXP_ST_MIS = 8'h40;
`else
  localparam logic [7:0] EXP_LD_MIS = 8'h00;
  localparam logic [7:0] EXP_ST_MIS = 8'h00;
`endif

  logic          clk;
  logic          rst;
  logic          flush;
  logic          issueValid;
  logic          issueReady;
  logic          issueCancel;
  logic [31:0]   issueRs1;
  logic [31:0]   issueRs2;
  logic [31:0]   issueImm;
  logic          issueRead;
  logic          issueUnsigned;
  logic          issueWord;
  logic          issueShort;
  logic          issueByte;
  logic [IW-1:0] issueInfo;
  logic          lsuValid;
  logic          lsuReady;
  logic          lsuCancel;
  logic          lsuRead;
  logic          lsuUnsigned;
  logic          lsuWord;
  logic          lsuShort;
  logic          lsuByte;
  logic [31:0]   lsuAddr;
  logic [31:0]   lsuWdata;
  logic [3:0]    lsuWmask;
  logic [IW-1:0] lsuInfo;

  int checkCount = 0;
  int errorCount = 0;

  hicore_agu dut (
    .clk                     (clk),
    .rst                     (rst),
    .flush                   (flush),
    .i_issue2agu_valid       (issueValid),
    .i_issue2agu_ready       (issueReady),
    .i_issue2agu_cancel      (issueCancel),
    .i_issue2agu_rs1         (issueRs1),
    .i_issue2agu_rs2         (issueRs2),
    .i_issue2agu_imm         (issueImm),
    .i_issue2agu_read        (issueRead),
    .i_issue2agu_unsigned    (issueUnsigned),
    .i_issue2agu_word_access (issueWord),
    .i_issue2agu_short_access(issueShort),
    .i_issue2agu_byte_access (issueByte),
    .i_issue2agu_info        (issueInfo),
    .o_agu2lsu_valid         (lsuValid),
    .o_agu2lsu_ready         (lsuReady),
    .o_agu2lsu_cancel        (lsuCancel),
    .o_agu2lsu_read          (lsuRead),
    .o_agu2lsu_unsigned      (lsuUnsigned),
    .o_agu2lsu_word_access   (lsuWord),
    .o_agu2lsu_short_access  (lsuShort),
    .o_agu2lsu_byte_access   (lsuByte),
    .o_agu2lsu_addr          (lsuAddr),
    .o_agu2lsu_wdata         (lsuWdata),
    .o_agu2lsu_wmask         (lsuWmask),
    .o_agu2lsu_info          (lsuInfo)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds an info bundle {rob_ptr, pc, irq=0, excp}
  function automatic logic [IW-1:0] mkInfo(input logic [3:0] rob,
                                           input logic [31:0] pc,
                                           input logic [7:0] excp);
    return {rob, pc, 1'b0, excp};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic c,
                               input logic [31:0] rs1, input logic [31:0] imm,
                               input logic [31:0] rs2, input logic rd,
                               input logic w, input logic s, input logic b,
                               input logic [IW-1:0] info);
    issueValid    = v;
    issueCancel   = c;
    issueRs1      = rs1;
    issueImm      = imm;
    issueRs2      = rs2;
    issueRead     = rd;
    issueUnsigned = 1'b0;
    issueWord     = w;
    issueShort    = s;
    issueByte     = b;
    issueInfo     = info;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Load word at base with zero offset
  task automatic pushLoadWord(input logic [31:0] base, input logic [3:0] rob);
    applyStimulus(1'b1, 1'b0, base, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
                  mkInfo(rob, base, 8'h00));
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    lsuReady = 1'b1;
    applyIdle();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_valid", lsuValid, 0);
    checkOutput("rst_cancel", lsuCancel, 0);
    checkOutput("rst_ready", issueReady, 1);
    checkOutput("rst_addr", lsuAddr, 0);
    checkOutput("rst_info", lsuInfo, 0);
    rst = 1'b0;

    // Store byte, one-cycle latency
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h1000, 32'h3, 32'hA5, 1'b0, 1'b0, 1'b0, 1'b1,
                  mkInfo(4'd1, 32'h40, 8'h00));
    #1;
    checkOutput("sb_pre_valid", lsuValid, 0);
    checkOutput("sb_ready", issueReady, 1);
    @(negedge clk);
    checkOutput("sb_valid", lsuValid, 1);
    checkOutput("sb_addr", lsuAddr, 32'h1003);
    checkOutput("sb_wmask", lsuWmask, 4'b1000);
    checkOutput("sb_wdata", lsuWdata, 32'hA5A5A5A5);
    checkOutput("sb_byte", lsuByte, 1);
    checkOutput("sb_read", lsuRead, 0);
    checkOutput("sb_info", lsuInfo, mkInfo(4'd1, 32'h40, 8'h00));

    // Back-to-back stores: short then misaligned word
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h2, 32'h1234BEEF, 1'b0, 1'b0, 1'b1, 1'b0,
                  mkInfo(4'd2, 32'h44, 8'h00));
    @(negedge clk);
    checkOutput("sh_addr", lsuAddr, 32'h12);
    checkOutput("sh_wmask", lsuWmask, 4'b1100);
    checkOutput("sh_wdata", lsuWdata, 32'hBEEFBEEF);
    applyStimulus(1'b1, 1'b0, 32'h11, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0,
                  mkInfo(4'd3, 32'h48, 8'h00));
    @(negedge clk);
    checkOutput("sw_valid", lsuValid, 1);
    checkOutput("sw_addr", lsuAddr, 32'h11);
    checkOutput("sw_wmask", lsuWmask, 4'b1111);
    checkOutput("sw_wdata", lsuWdata, 32'hCAFEF00D);
    checkOutput("sw_excp", lsuInfo, mkInfo(4'd3, 32'h48, EXP_ST_MIS));

    // Misaligned load word with clear excp
    pushLoadWord(32'h2002, 4'd4);
    @(negedge clk);
    checkOutput("lw_addr", lsuAddr, 32'h2002);
    checkOutput("lw_wmask", lsuWmask, 4'b0000);
    checkOutput("lw_read", lsuRead, 1);
    checkOutput("lw_excp", lsuInfo, mkInfo(4'd4, 32'h2002, EXP_LD_MIS));

    // Misaligned load with an earlier exception keeps its code
    applyStimulus(1'b1, 1'b0, 32'h2001, 32'h1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
                  mkInfo(4'd5, 32'h50, 8'h02));
    @(negedge clk);
    checkOutput("lw_keep_excp", lsuInfo, mkInfo(4'd5, 32'h50, 8'h02));

    // Wrap-around load short
    applyStimulus(1'b1, 1'b0, 32'hFFFFFFFF, 32'h2, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0,
                  mkInfo(4'd6, 32'h54, 8'h00));
    @(negedge clk);
    checkOutput("lh_wrap_addr", lsuAddr, 32'h00000001);
    checkOutput("lh_wrap_excp", lsuInfo, mkInfo(4'd6, 32'h54, EXP_LD_MIS));
    checkOutput("lh_wrap_short", lsuShort, 1);
    applyIdle();
    @(negedge clk);
    checkOutput("drain_valid", lsuValid, 0);

    // Three pushes against a stalled LSU, then drain in order
    lsuReady = 1'b0;
    pushLoadWord(32'h100, 4'd0);
    #1 checkOutput("bp_ready0", issueReady, 1);
    @(negedge clk);
    checkOutput("bp_head0", lsuAddr, 32'h100);
    pushLoadWord(32'h104, 4'd1);
    #1 checkOutput("bp_ready1", issueReady, 1);
    @(negedge clk);
    checkOutput("bp_hold0", lsuAddr, 32'h100);
    pushLoadWord(32'h108, 4'd2);
    #1 checkOutput("bp_ready2_full", issueReady, 0);
    @(negedge clk);
    checkOutput("bp_hold0_again", lsuAddr, 32'h100);
    checkOutput("bp_still_full", issueReady, 0);
    lsuReady = 1'b1;
    @(negedge clk);
    checkOutput("bp_head1", lsuAddr, 32'h104);
    checkOutput("bp_ready_one", issueReady, 1);
    @(negedge clk);
    checkOutput("bp_head2", lsuAddr, 32'h108);
    checkOutput("bp_head2_valid", lsuValid, 1);
    applyIdle();
    @(negedge clk);
    checkOutput("bp_empty", lsuValid, 0);

    // Cancel while full, then flush while full with a push offered
    lsuReady = 1'b0;
    pushLoadWord(32'h200, 4'd7);
    @(negedge clk);
    pushLoadWord(32'h204, 4'd8);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'h300, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
                  mkInfo(4'd9, 32'h300, 8'h00));
    #1 checkOutput("cancel_ready", issueReady, 1);
    @(negedge clk);
    applyIdle();
    #1;
    checkOutput("cancel_still_full", issueReady, 0);
    checkOutput("cancel_head", lsuAddr, 32'h200);
    flush = 1'b1;
    pushLoadWord(32'h400, 4'd10);
    #1;
    checkOutput("flush_cancel", lsuCancel, 1);
    checkOutput("flush_ready", issueReady, 0);
    @(negedge clk);
    flush = 1'b0;
    applyIdle();
    #1;
    checkOutput("flush_empty", lsuValid, 0);
    checkOutput("flush_cancel_off", lsuCancel, 0);
    checkOutput("flush_ready_back", issueReady, 1);
    @(negedge clk);
    checkOutput("flush_dropped", lsuValid, 0);
    flush = 1'b1;
    #1 checkOutput("flush_empty_nocancel", lsuCancel, 0);
    flush = 1'b0;

    // Reset during a pending transfer
    @(negedge clk);
    pushLoadWord(32'h500, 4'd11);
    @(negedge clk);
    checkOutput("mid_valid", lsuValid, 1);
    applyIdle();
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", lsuValid, 0);
    checkOutput("mid_rst_addr", lsuAddr, 0);
    checkOutput("mid_rst_ready", issueReady, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_valid", lsuValid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/hicore_agu.md
HICORE_AGU -- requirements
Module: HiCore_agu

Interface
REQ-001 SHALL have parameter AW, 32, address width; equal to `HiCore_ADDR_SIZE.
REQ-002 SHALL have parameter XLEN, 32, register width; equal to `HiCore_REG_SIZE.
REQ-003 SHALL have parameter IW, `HiCore_ISSUE2ALU_SIZE, info width: {rob_ptr, pc, irq, excp}.
REQ-004 clk  in  1  single clock; all state is on the rising edge.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 i_issue2agu_valid  in  1  request valid.
REQ-007 i_issue2agu_ready  out  1  request accepted when valid&ready.
REQ-008 i_issue2agu_cancel  in  1  request is squashed; it is consumed and then dropped.
REQ-009 i_issue2agu_rs1 / i_issue2agu_rs2 / i_issue2agu_imm  in  XLEN each  base, store data, offset.
REQ-010 i_issue2agu_read, _unsigned, _word_access, _short_access, _byte_access  in  1 each  op decode.
REQ-011 i_issue2agu_info  in  IW  tag bundle.
REQ-012 o_agu2lsu_valid / o_agu2lsu_ready  out/in  1  LSU handshake.
REQ-013 o_agu2lsu_cancel  out  1  head entry squashed.
REQ-014 o_agu2lsu_read, _unsigned, _word_access, _short_access, _byte_access  out  1 each.
REQ-015 o_agu2lsu_addr out AW; o_agu2lsu_wdata out XLEN; o_agu2lsu_wmask out XLEN/8; o_agu2lsu_info out IW.
REQ-016 flush  in  1  commit-stage pipeline flush.

Function
REQ-017 addr SHALL be rs1+imm, truncated mod 2^AW.
REQ-018 wmask SHALL be 0 for reads; for writes: byte 4'b0001<<addr[1:0], short 4'b0011<<addr[1:0], word 4'b1111, truncated to 4 bits.
REQ-019 wdata SHALL be {4{rs2[7:0]}} for byte, {2{rs2[15:0]}} for short, rs2 for word.
REQ-020 Misaligned = short with addr[0]=1, or word with addr[1:0]!=0.
REQ-021 If misaligned and incoming excp==0, the stored excp SHALL set bit `HiCore_EXCP_LD_MISALIGN (4) for reads or `HiCore_EXCP_ST_MISALIGN (6) for writes; otherwise excp passes unchanged.
REQ-022 Computed fields SHALL be stored in a 2-entry in-order buffer with states EMPTY, ONE, TWO.
REQ-023 i_issue2agu_ready SHALL be 1 when i_issue2agu_cancel=1, else (state!=TWO); it SHALL be a function of registered state and the cancel input only.
REQ-024 A push occurs on valid&ready&~cancel&~flush; a pop on o_agu2lsu_valid&o_agu2lsu_ready.
REQ-025 Transitions: EMPTY->ONE on push; ONE->TWO on push-only, ONE->EMPTY on pop-only, ONE stays ONE on push+pop; TWO->ONE on pop; no push in TWO.
REQ-026 Latency SHALL be 1 cycle from accepted push to o_agu2lsu_valid; sustained throughput 1 per cycle with ready=1.
REQ-027 o_agu2lsu_valid SHALL equal (state!=EMPTY); outputs show the oldest entry.
REQ-028 Outputs SHALL hold stable while valid&~ready.
REQ-029 flush SHALL force state EMPTY on the next edge, overriding push and pop in that cycle.
REQ-030 o_agu2lsu_cancel SHALL equal o_agu2lsu_valid & flush.

Reset
REQ-031 On rst: state EMPTY, o_agu2lsu_valid=0, o_agu2lsu_cancel=0, i_issue2agu_ready=1, entry storage cleared to 0.
REQ-032 Reset asserted mid-transfer SHALL discard all entries immediately; no output valid until a new push after reset release.

Configuration
REQ-033 Macro HiCore_AGU_MISALIGN_EN: defined -> REQ-020/021 active; undefined -> excp always passes unchanged and addr is forwarded unaligned.

Structure
REQ-034 `HiCore_EXCP_LD_MISALIGN and `HiCore_EXCP_ST_MISALIGN bit indices SHALL live in config.v beside the other HiCore width macros.
REQ-035 The 2-entry buffer SHALL be a sub-module HiCore_agu_skid, parameterised by data width; address/mask/data logic stays in HiCore_agu.

Verification
REQ-036 Store byte rs1=0x1000, imm=3, rs2=0xA5 -> addr 0x1003, wmask 4'b1000, wdata 0xA5A5A5A5, valid one cycle later.
REQ-037 Load word rs1=0x2002, imm=0 (macro defined) -> excp bit4 set, wmask 0; macro undefined -> excp unchanged.
REQ-038 Back-to-back 3 pushes with o_agu2lsu_ready=0 -> state TWO, i_issue2agu_ready=0 on third; release ready -> entries emerge in order 0,1,2.
REQ-039 flush while state=TWO and a push is offered -> o_agu2lsu_cancel=1 that cycle, state EMPTY next cycle, pushed op dropped.
REQ-040 i_issue2agu_cancel=1 with valid while state=TWO -> ready=1, no entry written, state unchanged.
REQ-041 rs1=0xFFFFFFFF, imm=2, load short -> addr 0x00000001, excp bit4 set (wrap-around plus misalignment).
